// File: rtl/axi_mst_rd_cmd.sv
// Command-driven AXI read master.
// Accepts read commands on a valid/ready port, rejects illegal ones with a
// tagged one-cycle cmd_err pulse, and issues AR for legal commands in
// acceptance order. Up to OST_DEPTH transactions can be outstanding, and each
// uses its slot index as ARID. R beats pass straight through to the user port.
// Each beat is tagged with its command's tag and beat index, and the last beat
// carries a merged error flag.
// Ports:
//   clk, rst                     clock, async active-high reset
//   cmd_*                        command input (valid/ready), cmd_err/_tag drop report
//   axi_mst_ar*                  AXI read-address channel
//   axi_mst_r*                   AXI read-data channel
//   rd_*                         user read-data stream (valid/ready)
//   ost_cnt                      slots in use (issued or awaiting data)
//   prot_err                     sticky R-channel protocol-violation flag
module axi_mst_rd_cmd #(
  parameter int unsigned OST_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr,
  input  logic [7:0]                         cmd_len,
  input  logic [2:0]                         cmd_size,
  input  logic [1:0]                         cmd_burst,
  input  logic [TAG_WIDTH-1:0]               cmd_tag,
  output logic                               cmd_err,
  output logic [TAG_WIDTH-1:0]               cmd_err_tag,
  output logic [ID_WIDTH-1:0]                axi_mst_arid,
  output logic [ADDR_WIDTH-1:0]              axi_mst_araddr,
  output logic [7:0]                         axi_mst_arlen,
  output logic [2:0]                         axi_mst_arsize,
  output logic [1:0]                         axi_mst_arburst,
  output logic                               axi_mst_arvalid,
  input  logic                               axi_mst_arready,
  input  logic [ID_WIDTH-1:0]                axi_mst_rid,
  input  logic [DATA_WIDTH-1:0]              axi_mst_rdata,
  input  logic [1:0]                         axi_mst_rresp,
  input  logic                               axi_mst_rlast,
  input  logic                               axi_mst_rvalid,
  output logic                               axi_mst_rready,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [TAG_WIDTH-1:0]               rd_tag,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic [7:0]                         rd_beat,
  output logic                               rd_last,
  output logic                               rd_err,
  output logic [$clog2(OST_DEPTH):0]         ost_cnt,
  output logic                               prot_err
);
  localparam int unsigned SLOT_W   = $clog2(OST_DEPTH);
  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_FREE, S_ISSUE, S_DATA} slot_state_t;

  slot_state_t            state_q [OST_DEPTH];
  slot_state_t            state_d [OST_DEPTH];
  logic [TAG_WIDTH-1:0]   tag_q   [OST_DEPTH];
  logic [ADDR_WIDTH-1:0]  addr_q  [OST_DEPTH];
  logic [7:0]             len_q   [OST_DEPTH];
  logic [2:0]             size_q  [OST_DEPTH];
  logic [1:0]             burst_q [OST_DEPTH];
  logic [7:0]             cnt_q   [OST_DEPTH];
  logic [1:0]             wresp_q [OST_DEPTH];

  logic [SLOT_W-1:0]      fifo_q  [OST_DEPTH];
  logic [SLOT_W-1:0]      wr_ptr, rd_ptr;
  logic [SLOT_W:0]        fifo_cnt;
  logic [SLOT_W-1:0]      ar_slot_q;

  logic                   any_free, legal, accept, alloc, drop;
  logic [SLOT_W-1:0]      free_idx;
  logic [15:0]            incr_end;
  logic [6:0]             low_mask;
  logic [SLOT_W-1:0]      rslot;
  logic                   tracked, r_hs, ar_hs, free_ev, viol;
  logic                   ar_load, pop, bypass, push;
  logic [1:0]             worst;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OST_DEPTH; i++) state_q[i] <= S_FREE;
    end else begin
      for (int unsigned i = 0; i < OST_DEPTH; i++) state_q[i] <= state_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    for (int unsigned i = 0; i < OST_DEPTH; i++) begin
      state_d[i] = state_q[i];
      if (alloc && free_idx == SLOT_W'(i))                  state_d[i] = S_ISSUE;
      if (ar_hs && ar_slot_q == SLOT_W'(i))                 state_d[i] = S_DATA;
      if (free_ev && rslot == SLOT_W'(i))                   state_d[i] = S_FREE;
    end
  end

  // Output / decode logic
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < OST_DEPTH; i++) begin
      if (!any_free && state_q[i] == S_FREE) begin
        any_free = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
    cmd_ready = any_free & ~rst;
    accept    = cmd_valid & cmd_ready;

    // 16-bit sum so an oversized beat count cannot wrap below the 4 KB limit
    incr_end = 16'(cmd_addr[11:0]) + (16'({1'b0, cmd_len} + 9'd1) << cmd_size);
    low_mask = 7'((8'd1 << cmd_size) - 8'd1);
    legal    = 1'b1;
    case (cmd_burst)
      2'b00:   if (cmd_len > 8'd15) legal = 1'b0;
      2'b01:   if (incr_end > 16'd4096) legal = 1'b0;
      2'b10:   if (!(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                   (|(cmd_addr[6:0] & low_mask))) legal = 1'b0;
      default: legal = 1'b0;
    endcase
    if (cmd_size > 3'(MAX_SIZE)) legal = 1'b0;
    alloc = accept & legal;
    drop  = accept & ~legal;

    // ARIDs above the slot range can never belong to a live slot
    rslot   = axi_mst_rid[SLOT_W-1:0];
    tracked = ((axi_mst_rid >> SLOT_W) == '0) && (state_q[rslot] == S_DATA);
    r_hs    = axi_mst_rvalid & rd_ready;
    worst   = (axi_mst_rresp > wresp_q[rslot]) ? axi_mst_rresp : wresp_q[rslot];
    free_ev = r_hs & tracked & axi_mst_rlast;
    viol    = r_hs & (~tracked |
                      (axi_mst_rlast  & (cnt_q[rslot] != len_q[rslot])) |
                      (~axi_mst_rlast & (cnt_q[rslot] == len_q[rslot])));

    axi_mst_rready = rd_ready;
    rd_valid       = axi_mst_rvalid;
    rd_data        = axi_mst_rdata;
    rd_last        = axi_mst_rlast;
    rd_tag         = tracked ? tag_q[rslot] : '0;
    rd_beat        = tracked ? cnt_q[rslot] : '0;
    rd_err         = axi_mst_rvalid & axi_mst_rlast &
                     (~tracked | (worst >= 2'd2) | (cnt_q[rslot] != len_q[rslot]));

    ar_hs   = axi_mst_arvalid & axi_mst_arready;
    ar_load = ~axi_mst_arvalid | axi_mst_arready;
    pop     = ar_load & (fifo_cnt != '0);
    // An empty issue queue lets a fresh command go straight to the AR register
    bypass  = ar_load & (fifo_cnt == '0) & alloc;
    push    = alloc & ~bypass;
  end

  assign axi_mst_arid = ID_WIDTH'(ar_slot_q);

  // Slot payload, beat counters and merged response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OST_DEPTH; i++) begin
        tag_q[i]   <= '0;
        addr_q[i]  <= '0;
        len_q[i]   <= '0;
        size_q[i]  <= '0;
        burst_q[i] <= '0;
        cnt_q[i]   <= '0;
        wresp_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        tag_q[free_idx]   <= cmd_tag;
        addr_q[free_idx]  <= cmd_addr;
        len_q[free_idx]   <= cmd_len;
        size_q[free_idx]  <= cmd_size;
        burst_q[free_idx] <= cmd_burst;
      end
      if (ar_hs) begin
        cnt_q[ar_slot_q]   <= '0;
        wresp_q[ar_slot_q] <= '0;
      end
      if (r_hs && tracked) begin
        wresp_q[rslot] <= worst;
        if (cnt_q[rslot] != len_q[rslot]) cnt_q[rslot] <= cnt_q[rslot] + 8'd1;
      end
    end
  end

  // Issue queue and registered AR channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OST_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      ar_slot_q       <= '0;
      axi_mst_araddr  <= '0;
      axi_mst_arlen   <= '0;
      axi_mst_arsize  <= '0;
      axi_mst_arburst <= '0;
      axi_mst_arvalid <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= free_idx;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (SLOT_W+1)'(push) - (SLOT_W+1)'(pop);
      if (ar_load) begin
        if (pop) begin
          axi_mst_arvalid <= 1'b1;
          ar_slot_q       <= fifo_q[rd_ptr];
          axi_mst_araddr  <= addr_q[fifo_q[rd_ptr]];
          axi_mst_arlen   <= len_q[fifo_q[rd_ptr]];
          axi_mst_arsize  <= size_q[fifo_q[rd_ptr]];
          axi_mst_arburst <= burst_q[fifo_q[rd_ptr]];
        end else if (bypass) begin
          axi_mst_arvalid <= 1'b1;
          ar_slot_q       <= free_idx;
          axi_mst_araddr  <= cmd_addr;
          axi_mst_arlen   <= cmd_len;
          axi_mst_arsize  <= cmd_size;
          axi_mst_arburst <= cmd_burst;
        end else begin
          axi_mst_arvalid <= 1'b0;
        end
      end
    end
  end

  // Occupancy and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ost_cnt     <= '0;
      cmd_err     <= 1'b0;
      cmd_err_tag <= '0;
      prot_err    <= 1'b0;
    end else begin
      ost_cnt     <= ost_cnt + (SLOT_W+1)'(alloc) - (SLOT_W+1)'(free_ev);
      cmd_err     <= drop;
      cmd_err_tag <= drop ? cmd_tag : '0;
      prot_err    <= prot_err | viol;
    end
  end
endmodule
